bcd_timer_ctrl: RTL and testbench
=================================

BCD_TIMER_CTRL -- requirements
Module: bcd_timer_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset. The ports are CLK (clock) and CLR (reset).
REQ-002 CLK  input  1  system clock; all state updates on the rising edge.
REQ-003 CLR  input  1  asynchronous active-low reset.
REQ-004 START  input  1  level; requests counting.
REQ-005 STOP  input  1  level; requests pause.
REQ-006 SET  input  1  level; requests load of PRESET.
REQ-007 MODE_UP  input  1  count direction: 1 = up, 0 = down. Sampled only when START is accepted.
REQ-008 TICK  input  1  one-cycle count-enable strobe.
REQ-009 PRESET  input  16  four BCD digits; [15:12] is the most significant.
REQ-010 Q  output  16  current four-digit BCD value.
REQ-011 RUNNING  output  1  high while in RUN.
REQ-012 DONE  output  1  high while in DONE.
REQ-013 ERR  output  1  one-cycle pulse: rejected SET.

Function
REQ-014 The FSM states SHALL be IDLE, RUN, PAUSE and DONE.
REQ-015 Command priority within a cycle SHALL be SET > STOP > START > TICK.
REQ-016 SET, any state, all PRESET digits 0-9:
- Q <= PRESET at the next edge.
- Next state is IDLE.
REQ-017 SET with any PRESET digit greater than 9:
- Q and state unchanged.
- ERR high for exactly the next cycle.
REQ-018 START in IDLE or PAUSE:
- Latches MODE_UP into an internal direction bit.
- Next state is RUN.
- START in RUN or DONE is ignored.
REQ-019 START when Q is already at the terminal value (0000 for down, 9999 for up) SHALL go to DONE instead of RUN.
REQ-020 STOP in RUN SHALL go to PAUSE with Q held. STOP in any other state is ignored.
REQ-021 In RUN with TICK=1 and no higher-priority command, Q SHALL step by one in BCD at the next edge. TICK in IDLE, PAUSE or DONE is ignored.
REQ-022 Up step: a digit at 9 wraps to 0 and carries into the next digit.
REQ-023 Down step: a digit at 0 wraps to 9 and borrows from the next digit.
REQ-024 Terminal detection:
- When a step produces the terminal value (0000 down, 9999 up), the state SHALL go to DONE on the same edge that Q is updated.
- Q never wraps past the terminal value.
REQ-025 DONE SHALL be held until SET or CLR.
REQ-026 Outputs are registered or state-decoded only:
- RUNNING = (state == RUN).
- DONE = (state == DONE).
- No combinational path from any input to any output.
REQ-027 Latency SHALL be one cycle from a command or TICK edge to the Q/state change.

Reset
REQ-028 CLR low SHALL immediately force the following, independent of CLK:
- Q = 0000.
- State = IDLE.
- RUNNING = 0, DONE = 0, ERR = 0.
- Direction bit = 1 (up).
REQ-029 CLR asserted mid-RUN SHALL abort the count. No TICK is honoured while CLR is low.
REQ-030 After CLR deasserts, the first edge SHALL process inputs normally.

Structure
REQ-031 A shared package bcd_timer_pkg SHALL hold:
- the state encoding (IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, DONE=2'd3);
- the digit count 4;
- the terminal constants 16'h0000 and 16'h9999.
REQ-032 The single sub-module bcd_digit SHALL be instantiated four times in a ripple carry/borrow chain. Its behaviour:
- One BCD digit with enable, direction, synchronous load and asynchronous active-low clear.
- Carry-out when enabled and wrapping.
REQ-033 The FSM, priority logic and terminal detection SHALL live in bcd_timer_ctrl.

Verification
REQ-034 Down count:
- Stimulus: PRESET=16'h0012, SET, then START with MODE_UP=0, then 12 TICKs.
- Response: Q steps 0012 -> 0011 -> 0010 -> 0009 ... -> 0000; DONE rises on the 12th TICK edge; further TICKs leave Q at 0000.
REQ-035 Up count with pause:
- Stimulus: PRESET=16'h0998, SET, START with MODE_UP=1, 2 TICKs, STOP, 3 TICKs, START, 1 TICK.
- Response: 0998 -> 0999 -> 1000; Q holds 1000 through PAUSE; then 1001.
REQ-036 Invalid SET:
- Stimulus: PRESET=16'h12A4, SET while in RUN at Q=0500.
- Response: ERR is a one-cycle pulse; Q stays 0500; state stays RUN.
REQ-037 Simultaneous commands:
- Stimulus: SET, STOP and TICK all high in the same cycle in RUN.
- Response: the load wins; state is IDLE; no step occurs.
REQ-038 Mid-run reset:
- Stimulus: CLR driven low between clock edges during RUN at Q=0437.
- Response: Q is 0000 and RUNNING is 0 before the next CLK edge.
REQ-039 Start at terminal:
- Stimulus: SET with PRESET=16'h9999, then START with MODE_UP=1.
- Response: DONE on the next edge; RUNNING never asserts.

Source files
------------

// File: rtl/bcd_timer_pkg.sv
// Shared types and constants for the four-digit BCD timer controller.
// Holds the FSM encoding, digit count, terminal values and a BCD validity helper.
package bcd_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int          NUM_DIGITS = 4;
  localparam logic [15:0] TERM_DOWN  = 16'h0000;
  localparam logic [15:0] TERM_UP    = 16'h9999;

  // One step before each terminal; a step from here lands on the terminal value.
  localparam logic [15:0] PRE_TERM_DOWN = 16'h0001;
  localparam logic [15:0] PRE_TERM_UP   = 16'h9998;

  function automatic logic bcd_valid(input logic [15:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit: synchronous load, enabled up/down step with wrap, carry/borrow out.
// Load has priority over the step enable.
module bcd_digit (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       en,
  input  logic       up,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic [3:0] d,
  output logic       co
);

  assign co = en && (up ? (d == 4'd9) : (d == 4'd0));

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      d <= 4'd0;
    end else if (load) begin
      d <= load_val;
    end else if (en) begin
      if (up) d <= (d == 4'd9) ? 4'd0 : d + 4'd1;
      else    d <= (d == 4'd0) ? 4'd9 : d - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_timer_ctrl.sv
// Four-digit BCD up/down timer: command priority SET > STOP > START > TICK,
// terminal detection into DONE, and a one-cycle ERR pulse on a rejected SET.
//
// state    | meaning
// ST_IDLE  | loaded or reset, waiting for START
// ST_RUN   | counting one BCD step per TICK
// ST_PAUSE | stopped mid-count, Q held
// ST_DONE  | terminal value reached, held until SET or CLR
module bcd_timer_ctrl
  import bcd_timer_pkg::*;
(
  input  logic        CLK,
  input  logic        CLR,
  input  logic        START,
  input  logic        STOP,
  input  logic        SET,
  input  logic        MODE_UP,
  input  logic        TICK,
  input  logic [15:0] PRESET,
  output logic [15:0] Q,
  output logic        RUNNING,
  output logic        DONE,
  output logic        ERR
);

  state_t state;
  logic   dir;
  logic   err;
  logic   preset_ok;
  logic   load;
  logic   step;
  logic   start_ok;
  logic   start_term;
  logic   step_term;
  logic [NUM_DIGITS:0] carry;

  assign preset_ok  = bcd_valid(PRESET);
  assign load       = SET && preset_ok;
  assign start_ok   = !SET && !STOP && START && (state == ST_IDLE || state == ST_PAUSE);
  assign step       = (state == ST_RUN) && TICK && !SET && !STOP && !START;
  assign start_term = MODE_UP ? (Q == TERM_UP) : (Q == TERM_DOWN);
  assign step_term  = dir ? (Q == PRE_TERM_UP) : (Q == PRE_TERM_DOWN);

  assign carry[0] = step;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .clk      (CLK),
      .clr_n    (CLR),
      .en       (carry[i]),
      .up       (dir),
      .load     (load),
      .load_val (PRESET[4*i +: 4]),
      .d        (Q[4*i +: 4]),
      .co       (carry[i+1])
    );
  end

  // A carry out of the top digit would mean the count passed a terminal; treat it as DONE too.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state <= ST_IDLE;
      dir   <= 1'b1;
      err   <= 1'b0;
    end else begin
      err <= SET && !preset_ok;
      if (SET) begin
        if (preset_ok) state <= ST_IDLE;
      end else if (STOP) begin
        if (state == ST_RUN) state <= ST_PAUSE;
      end else if (start_ok) begin
        dir   <= MODE_UP;
        state <= start_term ? ST_DONE : ST_RUN;
      end else if (step && (step_term || carry[NUM_DIGITS])) begin
        state <= ST_DONE;
      end
    end
  end

  assign RUNNING = (state == ST_RUN);
  assign DONE    = (state == ST_DONE);
  assign ERR     = err;

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// Scoreboard bench for bcd_timer_ctrl: an integer-arithmetic reference model
// queues expected outputs per driven cycle; a negedge monitor pops and compares.
module tb_bcd_timer_ctrl;

  logic        CLK = 1'b0;
  logic        CLR;
  logic        START, STOP, SET, MODE_UP, TICK;
  logic [15:0] PRESET;
  logic [15:0] Q;
  logic        RUNNING, DONE, ERR;

  int nchk = 0;
  int nerr = 0;

  typedef struct {
    string       tag;
    logic [15:0] q;
    logic        run;
    logic        done;
    logic        err;
  } exp_t;

  exp_t sb[$];

  // model state: 0 idle, 1 run, 2 pause, 3 done
  logic [15:0] m_q;
  int          m_st;
  logic        m_dir;

  bcd_timer_ctrl dut (
    .CLK     (CLK),
    .CLR     (CLR),
    .START   (START),
    .STOP    (STOP),
    .SET     (SET),
    .MODE_UP (MODE_UP),
    .TICK    (TICK),
    .PRESET  (PRESET),
    .Q       (Q),
    .RUNNING (RUNNING),
    .DONE    (DONE),
    .ERR     (ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int bcd2i(input logic [15:0] v);
    return int'(v[15:12]) * 1000 + int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [15:0] i2bcd(input int v);
    logic [15:0] r;
    r[15:12] = 4'((v / 1000) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[3:0]   = 4'(v % 10);
    return r;
  endfunction

  function automatic logic valid_bcd(input logic [15:0] v);
    return (v[15:12] <= 4'd9) && (v[11:8] <= 4'd9) && (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  task automatic model_reset();
    m_q   = 16'h0000;
    m_st  = 0;
    m_dir = 1'b1;
  endtask

  task automatic cyc(input string tag, input logic set, input logic stop, input logic start,
                     input logic mode, input logic tick, input logic [15:0] pre);
    exp_t e;
    logic m_err;
    int   v;
    @(negedge CLK);
    #1;
    SET = set; STOP = stop; START = start; MODE_UP = mode; TICK = tick; PRESET = pre;
    m_err = 1'b0;
    if (set) begin
      if (valid_bcd(pre)) begin
        m_q  = pre;
        m_st = 0;
      end else begin
        m_err = 1'b1;
      end
    end else if (stop) begin
      if (m_st == 1) m_st = 2;
    end else if (start) begin
      if (m_st == 0 || m_st == 2) begin
        m_dir = mode;
        if ((mode && m_q == 16'h9999) || (!mode && m_q == 16'h0000)) m_st = 3;
        else m_st = 1;
      end
    end else if (tick && m_st == 1) begin
      v = bcd2i(m_q) + (m_dir ? 1 : -1);
      m_q = i2bcd(v);
      if ((m_dir && v == 9999) || (!m_dir && v == 0)) m_st = 3;
    end
    e.tag  = tag;
    e.q    = m_q;
    e.run  = (m_st == 1);
    e.done = (m_st == 3);
    e.err  = m_err;
    sb.push_back(e);
    @(posedge CLK);
    #1;
    SET = 0; STOP = 0; START = 0; TICK = 0;
  endtask

  task automatic drain();
    @(negedge CLK);
    #2;
  endtask

  always @(negedge CLK) begin : mon
    exp_t e;
    if (CLR && sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.tag, ".q"},    32'(Q),       32'(e.q));
      chk({e.tag, ".run"},  32'(RUNNING), 32'(e.run));
      chk({e.tag, ".done"}, 32'(DONE),    32'(e.done));
      chk({e.tag, ".err"},  32'(ERR),     32'(e.err));
    end
  end

  initial begin
    logic [15:0] p;
    int r;
    CLR = 1'b0;
    SET = 0; STOP = 0; START = 0; MODE_UP = 0; TICK = 0; PRESET = 16'h0;
    model_reset();
    #13;
    chk("rst.q",    32'(Q),       32'h0);
    chk("rst.run",  32'(RUNNING), 32'h0);
    chk("rst.done", 32'(DONE),    32'h0);
    chk("rst.err",  32'(ERR),     32'h0);
    CLR = 1'b1;

    // down count 0012 -> 0000, extra ticks hold at terminal
    cyc("dn_set", 1, 0, 0, 0, 0, 16'h0012);
    cyc("dn_start", 0, 0, 1, 0, 0, 16'h0);
    for (int i = 0; i < 14; i++) cyc("dn_tick", 0, 0, 0, 0, 1, 16'h0);
    cyc("done_stop", 0, 1, 0, 0, 0, 16'h0);
    cyc("done_start", 0, 0, 1, 1, 0, 16'h0);

    // up count across digit carries, with pause
    cyc("up_set", 1, 0, 0, 0, 0, 16'h0998);
    cyc("up_start", 0, 0, 1, 1, 0, 16'h0);
    for (int i = 0; i < 2; i++) cyc("up_tick", 0, 0, 0, 0, 1, 16'h0);
    cyc("up_stop", 0, 1, 0, 0, 0, 16'h0);
    for (int i = 0; i < 3; i++) cyc("pause_tick", 0, 0, 0, 0, 1, 16'h0);
    cyc("resume", 0, 0, 1, 1, 0, 16'h0);
    cyc("up_tick2", 0, 0, 0, 0, 1, 16'h0);

    // rejected SET in RUN at 0500
    cyc("b_set", 1, 0, 0, 0, 0, 16'h0490);
    cyc("b_start", 0, 0, 1, 1, 0, 16'h0);
    for (int i = 0; i < 10; i++) cyc("b_tick", 0, 0, 0, 0, 1, 16'h0);
    cyc("bad_set", 1, 0, 0, 0, 0, 16'h12A4);
    cyc("after_bad", 0, 0, 0, 0, 0, 16'h0);

    // SET, STOP and TICK together in RUN
    cyc("sim_cmd", 1, 1, 0, 0, 1, 16'h0100);
    cyc("idle_tick", 0, 0, 0, 0, 1, 16'h0);

    // START at terminal values
    cyc("t_set9", 1, 0, 0, 0, 0, 16'h9999);
    cyc("t_start9", 0, 0, 1, 1, 0, 16'h0);
    cyc("t_tick9", 0, 0, 0, 0, 1, 16'h0);
    cyc("t_set0", 1, 0, 0, 0, 0, 16'h0000);
    cyc("t_start0", 0, 0, 1, 0, 0, 16'h0);
    cyc("t_set0b", 1, 0, 0, 0, 0, 16'h0000);
    cyc("t_start0up", 0, 0, 1, 1, 0, 16'h0);
    cyc("t_tick0up", 0, 0, 0, 0, 1, 16'h0);

    // random command mix
    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(0, 99));
      p = 16'h0;
      for (int d = 0; d < 4; d++) p[4*d +: 4] = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 3) == 0) p[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
      cyc("rnd", r < 6, r >= 6 && r < 12, r >= 12 && r < 22, 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 9) < 5), p);
    end

    // asynchronous reset mid-run at 0437
    cyc("r_set", 1, 0, 0, 0, 0, 16'h0430);
    cyc("r_start", 0, 0, 1, 1, 0, 16'h0);
    for (int i = 0; i < 7; i++) cyc("r_tick", 0, 0, 0, 0, 1, 16'h0);
    drain();
    chk("pre_rst.q", 32'(Q), 32'h0437);
    CLR = 1'b0;
    #1;
    chk("async_rst.q",    32'(Q),       32'h0);
    chk("async_rst.run",  32'(RUNNING), 32'h0);
    chk("async_rst.done", 32'(DONE),    32'h0);
    TICK = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_tick.q", 32'(Q), 32'h0);
    TICK = 1'b0;
    model_reset();
    @(negedge CLK);
    #2;
    CLR = 1'b1;

    // first edge after reset is processed normally
    cyc("post_rst_start", 0, 0, 1, 0, 0, 16'h0);
    cyc("post_rst_set", 1, 0, 0, 0, 0, 16'h0002);
    cyc("post_rst_start2", 0, 0, 1, 0, 0, 16'h0);
    for (int i = 0; i < 3; i++) cyc("post_rst_tick", 0, 0, 0, 0, 1, 16'h0);
    drain();

    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
